// File: rtl/register_file_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_sb_if
// Description : Bundle of the decode-side (read / reserve) and write-back-side
//               (write / release) signals of the scoreboarded register file.
//               master : pipeline side (decode + write-back) driving requests
//               slave  : register file answering with data and busy status
// Ports       : read_reg1/2, use1/2      -> operand addresses and usage
//               read_data1/2, busy1/2    <- operand data and availability
//               stall, any_busy          <- decode stall, any pending write
//               rsv_en, rsv_reg, rsv_ok  <> destination reservation
//               write, write_reg/_data   -> write-back (also releases)
//               flush                    -> drop all pending reservations
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_sb_if #(
  parameter int N     = 32,
  parameter int DEPTH = 32
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [N-1:0]      read_data1;
  logic [N-1:0]      read_data2;
  logic              use1;
  logic              use2;
  logic              busy1;
  logic              busy2;
  logic              stall;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_reg;
  logic              rsv_ok;
  logic              write;
  logic [ADDR_W-1:0] write_reg;
  logic [N-1:0]      write_data;
  logic              flush;
  logic              any_busy;

  modport master (
    output read_reg1, read_reg2, use1, use2,
    output rsv_en, rsv_reg, write, write_reg, write_data, flush,
    input  read_data1, read_data2, busy1, busy2, stall, rsv_ok, any_busy
  );

  modport slave (
    input  read_reg1, read_reg2, use1, use2,
    input  rsv_en, rsv_reg, write, write_reg, write_data, flush,
    output read_data1, read_data2, busy1, busy2, stall, rsv_ok, any_busy
  );
endinterface
`default_nettype wire

// File: rtl/register_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : register_file_sb
// Description : Two-read-port register file with write-through bypass and a
//               per-register pending-write counter (scoreboard). Decode
//               reserves a destination, write-back releases it; the counter
//               drives operand busy and decode stall indications.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-low reset
//               bus  - register_file_sb_if.slave (read, reserve, write-back,
//                      flush, busy/stall status)
// Parameters  : N        data width
//               DEPTH    number of registers (power of two, >= 2)
//               CNT_W    pending counter width (max 2^CNT_W-1 outstanding)
//               ZERO_REG 1 = register 0 reads zero, never written or busy
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_sb #(
  parameter int N        = 32,
  parameter int DEPTH    = 32,
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  register_file_sb_if.slave bus
);

  localparam int               ADDR_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Register 0 is treated as a constant only when ZERO_REG is set.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [N-1:0]     mem_q [DEPTH];
  logic [N-1:0]     mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];

  logic [DEPTH-1:0] busy_state;

  // --------------------------------------------------------------------------
  // Write-back / reservation qualification
  // --------------------------------------------------------------------------
  logic wr_store;      // write-back lands in storage
  logic rel_en;        // write-back retires one pending count
  logic rsv_sat;       // reserved register already at max outstanding writes
  logic rsv_rel_same;  // the saturated register is being released this cycle
  logic rsv_ok;        // reservation accepted
  logic rsv_count;     // accepted reservation that actually bumps a counter

  always_comb begin
    wr_store     = bus.write && !is_zero_reg(bus.write_reg);
    rel_en       = bus.write && (cnt_q[bus.write_reg] != '0);
    rsv_sat      = (cnt_q[bus.rsv_reg] == CNT_MAX);
    rsv_rel_same = rel_en && (bus.write_reg == bus.rsv_reg);
    // A saturated register can still take a reservation when one of its
    // outstanding writes retires in the same cycle (net count unchanged).
    rsv_ok       = bus.rsv_en && !bus.flush && !(rsv_sat && !rsv_rel_same);
    rsv_count    = rsv_ok && !is_zero_reg(bus.rsv_reg);
  end

  always_comb begin
    busy_state = '0;
    for (int r = 0; r < DEPTH; r++) begin
      busy_state[r] = (cnt_q[r] != '0);
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_addr [2];
  logic [N-1:0]      rd_data [2];
  logic [1:0]        rd_busy;

  assign rd_addr[0] = bus.read_reg1;
  assign rd_addr[1] = bus.read_reg2;

  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem_q[rd_addr[p]];
      if (is_zero_reg(rd_addr[p])) begin
        rd_data[p] = '0;
      end else if (bus.write && (bus.write_reg == rd_addr[p])) begin
        rd_data[p] = bus.write_data;
      end

      // The last outstanding write arriving now is covered by the bypass,
      // unless a younger reservation of the same register is accepted in
      // the same cycle (the counter then stays at one).
      rd_busy[p] = busy_state[rd_addr[p]] &&
                   !(bus.write && (bus.write_reg == rd_addr[p]) &&
                     (cnt_q[rd_addr[p]] == CNT_ONE) &&
                     !(rsv_ok && (bus.rsv_reg == rd_addr[p])));
    end
  end

  assign bus.read_data1 = rd_data[0];
  assign bus.read_data2 = rd_data[1];
  assign bus.busy1      = rd_busy[0];
  assign bus.busy2      = rd_busy[1];
  assign bus.stall      = (bus.use1 && rd_busy[0]) || (bus.use2 && rd_busy[1]);
  assign bus.rsv_ok     = rsv_ok;
  // Pure state view: same-cycle releases are deliberately not bypassed here.
  assign bus.any_busy   = |busy_state;

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_d[r] = mem_q[r];
      if (wr_store && (bus.write_reg == ADDR_W'(r))) begin
        mem_d[r] = bus.write_data;
      end

      if (bus.flush) begin
        cnt_d[r] = '0;
      end else begin
        cnt_d[r] = cnt_q[r]
                 + CNT_W'(rsv_count && (bus.rsv_reg == ADDR_W'(r)))
                 - CNT_W'(rel_en && (bus.write_reg == ADDR_W'(r)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= mem_d[r];
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_sb
// Description : Scoreboard bench for register_file_sb. A stimulus process
//               drives one request per cycle, predicts the combinational
//               response from an array-based model and queues it; a monitor
//               on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_sb;

  localparam int N         = 32;
  localparam int DEPTH     = 32;
  localparam int CNT_W     = 2;
  localparam int CNT_LIMIT = (1 << CNT_W) - 1;
  localparam int N_RANDOM  = 3000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  register_file_sb_if #(.N(N), .DEPTH(DEPTH)) bif ();

  register_file_sb #(
    .N        (N),
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W),
    .ZERO_REG (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        u1;
    logic        u2;
    logic        rsv_en;
    logic [4:0]  rsv_reg;
    logic        wr;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        flush;
  } stim_t;

  typedef struct {
    int          cyc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        busy1;
    logic        busy2;
    logic        stall;
    logic        rsv_ok;
    logic        any_busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model: plain data array and "writes still owed" per register.
  logic [31:0] m_mem [DEPTH];
  int          m_owed [DEPTH];

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.r1 = '0; s.r2 = '0; s.u1 = 1'b0; s.u2 = 1'b0;
    s.rsv_en = 1'b0; s.rsv_reg = '0; s.wr = 1'b0; s.wreg = '0;
    s.wdata = '0; s.flush = 1'b0;
    return s;
  endfunction

  function automatic logic [4:0] rnd_addr();
    // Mostly a small window so reservations and releases collide often.
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] model_read(input stim_t s, input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (s.wr && s.wreg == r) return s.wdata;
    return m_mem[r];
  endfunction

  // Busy if writes are owed now and some remain owed once this cycle's
  // write-back and any same-cycle (younger) reservation are accounted for.
  function automatic logic model_busy(input stim_t s, input logic [4:0] r, input logic ok);
    int left;
    if (r == 0 || m_owed[r] == 0) return 1'b0;
    left = m_owed[r];
    if (s.wr && s.wreg == r) left = left - 1;
    if (ok && s.rsv_reg == r) left = left + 1;
    return left > 0;
  endfunction

  task automatic clear_model(input bit data_too);
    for (int r = 0; r < DEPTH; r++) begin
      m_owed[r] = 0;
      if (data_too) m_mem[r] = 32'h0;
    end
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    logic ok;
    rst              = s.rst_n;
    bif.read_reg1    = s.r1;
    bif.read_reg2    = s.r2;
    bif.use1         = s.u1;
    bif.use2         = s.u2;
    bif.rsv_en       = s.rsv_en;
    bif.rsv_reg      = s.rsv_reg;
    bif.write        = s.wr;
    bif.write_reg    = s.wreg;
    bif.write_data   = s.wdata;
    bif.flush        = s.flush;

    ok = s.rsv_en && !s.flush &&
         !(m_owed[s.rsv_reg] == CNT_LIMIT && !(s.wr && s.wreg == s.rsv_reg));

    e.cyc      = cycle;
    e.rd1      = model_read(s, s.r1);
    e.rd2      = model_read(s, s.r2);
    e.busy1    = model_busy(s, s.r1, ok);
    e.busy2    = model_busy(s, s.r2, ok);
    e.stall    = (s.u1 && e.busy1) || (s.u2 && e.busy2);
    e.rsv_ok   = ok;
    e.any_busy = 1'b0;
    for (int r = 0; r < DEPTH; r++) if (m_owed[r] > 0) e.any_busy = 1'b1;
    exp_q.push_back(e);

    if (!s.rst_n) begin
      clear_model(1'b1);
    end else begin
      if (s.wr && s.wreg != 0) m_mem[s.wreg] = s.wdata;
      if (s.flush) begin
        clear_model(1'b0);
      end else begin
        if (s.wr && m_owed[s.wreg] > 0) m_owed[s.wreg] = m_owed[s.wreg] - 1;
        if (ok && s.rsv_reg != 0) m_owed[s.rsv_reg] = m_owed[s.rsv_reg] + 1;
      end
    end

    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Monitor: the DUT presents a response every cycle; compare mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("read_data1", e.cyc, bif.read_data1, e.rd1);
      chk("read_data2", e.cyc, bif.read_data2, e.rd2);
      chk("busy1",      e.cyc, 32'(bif.busy1),    32'(e.busy1));
      chk("busy2",      e.cyc, 32'(bif.busy2),    32'(e.busy2));
      chk("stall",      e.cyc, 32'(bif.stall),    32'(e.stall));
      chk("rsv_ok",     e.cyc, 32'(bif.rsv_ok),   32'(e.rsv_ok));
      chk("any_busy",   e.cyc, 32'(bif.any_busy), 32'(e.any_busy));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    stim_t s;
    s = idle();
    s.rst_n = 1'b0;
    rst = 1'b0;
    bif.read_reg1 = '0; bif.read_reg2 = '0; bif.use1 = 1'b0; bif.use2 = 1'b0;
    bif.rsv_en = 1'b0; bif.rsv_reg = '0; bif.write = 1'b0; bif.write_reg = '0;
    bif.write_data = '0; bif.flush = 1'b0;
    clear_model(1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Reset: dirty some state, then hold reset for two cycles.
    for (int i = 0; i < 6; i++) begin
      s = idle();
      s.wr = 1'b1; s.wreg = 5'($urandom_range(1, 31)); s.wdata = $urandom;
      s.rsv_en = 1'b1; s.rsv_reg = 5'($urandom_range(1, 31));
      s.r1 = s.wreg; s.r2 = s.rsv_reg; s.u2 = 1'b1;
      apply(s);
    end
    for (int i = 0; i < 2; i++) begin
      s = idle(); s.rst_n = 1'b0; s.r1 = rnd_addr(); s.r2 = rnd_addr();
      apply(s);
    end
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.r1 = 5'($urandom_range(0, 31)); s.r2 = 5'($urandom_range(0, 31));
      s.u1 = 1'b1; s.u2 = 1'b1;
      apply(s);
    end

    // Bypass then storage.
    s = idle(); s.wr = 1'b1; s.wreg = 5'd5; s.wdata = 32'hDEADBEEF; s.r1 = 5'd5;
    apply(s);
    s = idle(); s.r1 = 5'd5;
    apply(s);

    // Reserve reg 7, release three cycles later.
    s = idle(); s.rsv_en = 1'b1; s.rsv_reg = 5'd7; s.r1 = 5'd7; s.u1 = 1'b1;
    apply(s);
    for (int i = 0; i < 2; i++) begin
      s = idle(); s.r1 = 5'd7; s.u1 = 1'b1;
      apply(s);
    end
    s = idle(); s.wr = 1'b1; s.wreg = 5'd7; s.wdata = 32'h0BADF00D; s.r1 = 5'd7; s.u1 = 1'b1;
    apply(s);
    s = idle(); s.r1 = 5'd7; s.u1 = 1'b1;
    apply(s);

    // Saturation on reg 9.
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.rsv_en = 1'b1; s.rsv_reg = 5'd9; s.r1 = 5'd9; s.u1 = 1'b1;
      apply(s);
    end
    s = idle(); s.rsv_en = 1'b1; s.rsv_reg = 5'd9; s.wr = 1'b1; s.wreg = 5'd9;
    s.wdata = 32'h99; s.r1 = 5'd9; s.u1 = 1'b1;
    apply(s);
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.wr = 1'b1; s.wreg = 5'd9; s.wdata = $urandom; s.r1 = 5'd9; s.u1 = 1'b1;
      apply(s);
    end

    // Zero register.
    s = idle(); s.wr = 1'b1; s.wreg = 5'd0; s.wdata = 32'h1234; s.rsv_en = 1'b1;
    s.rsv_reg = 5'd0; s.u1 = 1'b1; s.u2 = 1'b1;
    apply(s);
    s = idle(); s.u1 = 1'b1;
    apply(s);

    // Flush with a simultaneous write.
    for (int i = 1; i <= 3; i++) begin
      s = idle(); s.rsv_en = 1'b1; s.rsv_reg = 5'(i);
      apply(s);
    end
    s = idle(); s.flush = 1'b1; s.wr = 1'b1; s.wreg = 5'd4; s.wdata = 32'hA5;
    s.r1 = 5'd4; s.r2 = 5'd1; s.u2 = 1'b1;
    apply(s);
    s = idle(); s.r1 = 5'd4; s.r2 = 5'd2; s.u2 = 1'b1;
    apply(s);

    // Randomised traffic.
    for (int i = 0; i < N_RANDOM; i++) begin
      s = idle();
      s.rst_n   = ($urandom_range(0, 299) != 0);
      s.r1      = rnd_addr();
      s.r2      = rnd_addr();
      s.u1      = 1'($urandom_range(0, 1));
      s.u2      = 1'($urandom_range(0, 1));
      s.rsv_en  = ($urandom_range(0, 9) < 5);
      s.rsv_reg = rnd_addr();
      s.wr      = ($urandom_range(0, 9) < 4);
      s.wreg    = rnd_addr();
      s.wdata   = $urandom;
      s.flush   = ($urandom_range(0, 49) == 0);
      apply(s);
    end

    s = idle();
    rst = s.rst_n;
    bif.rsv_en = 1'b0; bif.write = 1'b0; bif.flush = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
